// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the MulDiv unit.
package muldiv_pkg;

    // Operation encoding as presented on the op port
    typedef enum logic [1:0] {
        MUL    = 2'b00,
        MULH   = 2'b01,
        MULHSU = 2'b10,
        MULHU  = 2'b11
    } mul_op_t;

    // Partial-product select feeding the shared 4:1 mux; 2'b11 is the unused leg
    typedef enum logic [1:0] {
        BSEL_ZERO = 2'b00,
        BSEL_M    = 2'b01,
        BSEL_2M   = 2'b10
    } booth_sel_t;

    // Sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } mul_state_t;

    // Radix-4 iterations needed to scan a (width+2)-bit extended multiplier
    function automatic int booth_iters(input int width);
        return width / 2 + 1;
    endfunction

endpackage

// File: rtl/booth4_enc.sv
// Radix-4 Booth recoder: triplet {b[2i+1], b[2i], b[2i-1]} to select plus negate.
module booth4_enc
    import muldiv_pkg::*;
(
    input  logic [2:0]  trip_i,
    output booth_sel_t  sel_o,
    output logic        neg_o
);

    // 000 and 111 both recode to zero; keep neg low there so no stray carry-in
    always_comb begin
        sel_o = BSEL_ZERO;
        neg_o = 1'b0;
        case (trip_i)
            3'b001, 3'b010: sel_o = BSEL_M;
            3'b011:         sel_o = BSEL_2M;
            3'b100: begin
                sel_o = BSEL_2M;
                neg_o = 1'b1;
            end
            3'b101, 3'b110: begin
                sel_o = BSEL_M;
                neg_o = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/booth4_mul_seq.sv
// Iterative radix-4 Booth multiplier for MUL/MULH/MULHSU/MULHU, one op in flight.
module booth4_mul_seq
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result
);

    localparam int ITERS = booth_iters(WIDTH);
    localparam int EW    = WIDTH + 2;
    localparam int AW    = WIDTH + 3;
    localparam int CW    = $clog2(ITERS);

    mul_state_t       state_q, state_d;
    mul_op_t          op_q, op_d;
    logic [EW-1:0]    mcand_q, mcand_d;
    logic [EW-1:0]    mult_q, mult_d;
    logic             prev_q, prev_d;
    logic [AW-1:0]    acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;

    booth_sel_t       sel;
    logic             neg;
    logic [AW-1:0]    m_ext;
    logic [AW-1:0]    pp;
    logic [AW-1:0]    acc_sum;
    logic [AW-1:0]    acc_shr;
    logic [EW-1:0]    mult_nx;
    logic             a_signed;
    logic             b_signed;

    booth4_enc u_enc (
        .trip_i ({mult_q[1:0], prev_q}),
        .sel_o  (sel),
        .neg_o  (neg)
    );

    // Shared 4:1 partial-product mux; fourth leg tied to zero
    always_comb begin
        m_ext = {{(AW - EW){mcand_q[EW-1]}}, mcand_q};
        case (sel)
            BSEL_ZERO: pp = '0;
            BSEL_M:    pp = m_ext;
            BSEL_2M:   pp = m_ext << 1;
            default:   pp = '0;
        endcase
    end

    // Add the signed partial product (one's complement plus carry-in) and form the shifted pair
    always_comb begin
        acc_sum = acc_q + (neg ? ~pp : pp) + {{(AW - 1){1'b0}}, neg};
        acc_shr = {{2{acc_sum[AW-1]}}, acc_sum[AW-1:2]};
        mult_nx = {acc_sum[1:0], mult_q[EW-1:2]};
    end

    // Sequencer next state, handshake outputs and datapath loads
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        mcand_d   = mcand_q;
        mult_d    = mult_q;
        prev_d    = prev_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        a_signed  = (mul_op_t'(op) != MULHU);
        b_signed  = (mul_op_t'(op) == MUL) || (mul_op_t'(op) == MULH);
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    op_d    = mul_op_t'(op);
                    mcand_d = {{2{a_signed & op_a[WIDTH-1]}}, op_a};
                    mult_d  = {{2{b_signed & op_b[WIDTH-1]}}, op_b};
                    prev_d  = 1'b0;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                acc_d  = acc_shr;
                mult_d = mult_nx;
                prev_d = mult_q[1];
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CW'(ITERS - 1)) begin
                    state_d  = DONE;
                    // Product now sits in {acc, mult}; mult holds the low WIDTH+2 bits
                    result_d = (op_q == MUL) ? mult_nx[WIDTH-1:0]
                                             : {acc_shr[WIDTH-3:0], mult_nx[WIDTH+1:WIDTH]};
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; flush behaves exactly like reset
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state_q  <= IDLE;
            op_q     <= MUL;
            mcand_q  <= '0;
            mult_q   <= '0;
            prev_q   <= 1'b0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            mcand_q  <= mcand_d;
            mult_q   <= mult_d;
            prev_q   <= prev_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    assign result = result_q;

endmodule

// File: tb/tb_booth4_mul_seq.sv
// Self-checking bench for booth4_mul_seq against a 64-bit arithmetic reference.
module tb_booth4_mul_seq;

    localparam int W   = 32;
    localparam int LAT = W / 2 + 2;   // cycle of first out_valid after handshake cycle 0

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    op;
    logic [W-1:0]  op_a;
    logic [W-1:0]  op_b;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  result;

    int pass_cnt = 0;
    int total_cnt = 0;

    booth4_mul_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] ref_mul(input logic [1:0] o, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        logic [2*W-1:0] ea, eb, p;
        ea = (o != 2'b11) ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
        eb = (o == 2'b00 || o == 2'b01) ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
        p  = ea * eb;
        return (o == 2'b00) ? p[W-1:0] : p[2*W-1:W];
    endfunction

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return '0;
            1: return 32'h0000_0001;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one op from IDLE and wait for the result; scrambles inputs after the handshake.
    task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic consume, output logic [W-1:0] res, output int lat,
                          output logic busy_ok);
        busy_ok  = 1'b1;
        op       = o;
        op_a     = a;
        op_b     = b;
        in_valid = 1'b1;
        out_ready = consume;
        step();
        in_valid = 1'b0;
        op       = 2'($urandom);
        op_a     = $urandom;
        op_b     = $urandom;
        lat = 1;
        while (!out_valid && lat < 3 * LAT) begin
            if (in_ready !== 1'b0) busy_ok = 1'b0;
            step();
            lat++;
        end
        if (in_ready !== 1'b0) busy_ok = 1'b0;
        res = result;
        if (consume) step();
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op = '0; op_a = '0; op_b = '0;
        repeat (3) step();
        rst = 1'b0;
        step();
        total_cnt++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready);
        else pass_cnt++;
        total_cnt++;
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid);
        else pass_cnt++;
        total_cnt++;
        if (result !== '0) $display("FAIL reset_result got %h want 0", result);
        else pass_cnt++;
    endtask

    task automatic test_directed();
        logic [1:0]   ops [8] = '{2'b00, 2'b01, 2'b00, 2'b11, 2'b10, 2'b01, 2'b00, 2'b11};
        logic [W-1:0] as  [8] = '{32'd7, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF,
                                  32'hFFFF_FFFF, 32'hFFFF_FFFB, 32'hFFFF_FFFB, 32'h1234_5678};
        logic [W-1:0] bs  [8] = '{32'd6, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF,
                                  32'hFFFF_FFFF, 32'd3, 32'd3, 32'h9ABC_DEF0};
        logic [W-1:0] exp [8] = '{32'h0000_002A, 32'h4000_0000, 32'h0000_0000, 32'hFFFF_FFFE,
                                  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 32'h0B00_EA4E};
        logic [W-1:0] res;
        int           lat;
        logic         busy_ok;
        for (int i = 0; i < 8; i++) begin
            run_op(ops[i], as[i], bs[i], 1'b1, res, lat, busy_ok);
            total_cnt++;
            if (res !== exp[i]) $display("FAIL directed_%0d_result got %h want %h", i, res, exp[i]);
            else pass_cnt++;
            total_cnt++;
            if (lat != LAT) $display("FAIL directed_%0d_latency got %0d want %0d", i, lat, LAT);
            else pass_cnt++;
            total_cnt++;
            if (busy_ok !== 1'b1) $display("FAIL directed_%0d_in_ready_busy got 1 want 0", i);
            else pass_cnt++;
            total_cnt++;
            if (in_ready !== 1'b1) $display("FAIL directed_%0d_idle_after got %b want 1", i, in_ready);
            else pass_cnt++;
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] res, exp;
        int           lat;
        logic         busy_ok;
        logic         held_ok;
        exp = ref_mul(2'b01, 32'hDEAD_BEEF, 32'h1357_9BDF);
        run_op(2'b01, 32'hDEAD_BEEF, 32'h1357_9BDF, 1'b0, res, lat, busy_ok);
        total_cnt++;
        if (res !== exp) $display("FAIL bp_result got %h want %h", res, exp);
        else pass_cnt++;
        held_ok  = 1'b1;
        in_valid = 1'b1;
        op       = 2'b11;
        op_a     = 32'h1111_1111;
        op_b     = 32'h2222_2222;
        for (int i = 0; i < 5; i++) begin
            step();
            if (out_valid !== 1'b1 || result !== exp || in_ready !== 1'b0) held_ok = 1'b0;
        end
        total_cnt++;
        if (held_ok !== 1'b1) $display("FAIL bp_hold got out_valid=%b result=%h in_ready=%b want 1/%h/0",
                                       out_valid, result, in_ready, exp);
        else pass_cnt++;
        out_ready = 1'b1;
        in_valid  = 1'b0;
        step();
        total_cnt++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL bp_release got out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
        else pass_cnt++;
        exp = ref_mul(2'b10, 32'h8000_0001, 32'hFFFF_FFFE);
        run_op(2'b10, 32'h8000_0001, 32'hFFFF_FFFE, 1'b1, res, lat, busy_ok);
        total_cnt++;
        if (res !== exp || lat != LAT) $display("FAIL bp_next got %h lat %0d want %h lat %0d",
                                                res, lat, exp, LAT);
        else pass_cnt++;
    endtask

    // Abort at BUSY iteration 8 using flush (use_rst=0) or rst (use_rst=1)
    task automatic test_abort(input logic use_rst);
        logic [W-1:0] res;
        int           lat;
        logic         busy_ok;
        logic         seen;
        op = 2'b00; op_a = 32'h0000_0123; op_b = 32'h0000_0456;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (8) step();
        if (use_rst) rst = 1'b1; else flush = 1'b1;
        step();
        rst = 1'b0; flush = 1'b0;
        total_cnt++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== '0)
            $display("FAIL abort%0d_state got in_ready=%b out_valid=%b result=%h want 1/0/0",
                     use_rst, in_ready, out_valid, result);
        else pass_cnt++;
        seen = 1'b0;
        repeat (LAT + 5) begin
            if (out_valid) seen = 1'b1;
            step();
        end
        total_cnt++;
        if (seen !== 1'b0) $display("FAIL abort%0d_no_result got out_valid=1 want 0", use_rst);
        else pass_cnt++;
        run_op(2'b11, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, res, lat, busy_ok);
        total_cnt++;
        if (res !== 32'h0B00_EA4E || lat != LAT)
            $display("FAIL abort%0d_followup got %h lat %0d want 0b00ea4e lat %0d",
                     use_rst, res, lat, LAT);
        else pass_cnt++;
    endtask

    task automatic test_flush_on_accept();
        logic seen;
        op = 2'b00; op_a = 32'd9; op_b = 32'd9;
        in_valid = 1'b1;
        flush    = 1'b1;
        step();
        in_valid = 1'b0;
        flush    = 1'b0;
        seen = 1'b0;
        repeat (LAT + 5) begin
            if (out_valid || !in_ready) seen = 1'b1;
            step();
        end
        total_cnt++;
        if (seen !== 1'b0) $display("FAIL flush_accept got busy/valid=1 want idle");
        else pass_cnt++;
    endtask

    task automatic test_random(input int n);
        logic [1:0]   o;
        logic [W-1:0] a, b, res, exp;
        int           lat;
        logic         busy_ok;
        for (int i = 0; i < n; i++) begin
            o = 2'($urandom);
            a = pick_operand();
            b = pick_operand();
            exp = ref_mul(o, a, b);
            run_op(o, a, b, 1'b1, res, lat, busy_ok);
            total_cnt++;
            if (res !== exp) $display("FAIL rand_%0d_result op=%0d a=%h b=%h got %h want %h",
                                      i, o, a, b, res, exp);
            else pass_cnt++;
            total_cnt++;
            if (lat != LAT || busy_ok !== 1'b1)
                $display("FAIL rand_%0d_timing got lat %0d busy_ok %b want %0d 1", i, lat, busy_ok, LAT);
            else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_abort(1'b0);
        test_abort(1'b1);
        test_flush_on_accept();
        test_random(2000);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
